spi_reg_slave: RTL

- Parametrised successor to the SID-bus SPI slave: receives register-write frames from the ESP over SPI mode 0 and presents them to the SID register file as addr/data/write_en.
- Adds configurable address/data widths, multi-word burst frames with address auto-increment, and frame-error detection.
- Sits between the CPLD SPI pins and the SID register interface.
- All SPI inputs are oversampled in the system clock domain.

---
 rtl/spi_reg_slave.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode 0 register-write slave for the SID register file.
// Receives an 8-bit command (bit7 = R/nW, low bits = start address) followed by
// one or more DATA_W-bit words; each complete word produces a one-clk write_en
// strobe with addr/data. All SPI pins are oversampled in the clk domain.
// Optional feature: define SPI_READBACK_EN to add the rd_data input and shift
// read data out on miso; otherwise miso is tied low and reads are skipped.
module spi_reg_slave #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              sclk,
  input  logic              mosi,
`ifdef SPI_READBACK_EN
  input  logic [DATA_W-1:0] rd_data,
`endif
  output logic              miso,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              write_en,
  output logic              data_rdy,
  output logic              busy,
  output logic              frame_err
);

  localparam int SR_W  = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CMD_BITS  = CNT_W'(8);
  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_W);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_SKIP = 3'd3;
`ifdef SPI_READBACK_EN
  localparam logic [2:0] ST_READ = 3'd4;
`endif

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic ss_s, sclk_s, mosi_s;
  logic ss_q, sclk_q;
  logic rise_r, fall_r, ss_fall_r, ss_rise_r, mosi_r;

  logic [2:0]        state;
  logic [CNT_W-1:0]  bit_cnt, cnt_inc, cnt_nxt;
  logic [SR_W-2:0]   shift_reg;
  logic [SR_W-1:0]   shift_nxt;
  logic [ADDR_W-1:0] addr_reg, addr_inc;
  logic              in_word, cmd_done, word_done, ld_pend;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Synchronise the raw SPI pins; preset to the idle bus levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  // Register edge pulses together with the mosi sample so every event
  // reaches the FSM on the same clk, SYNC_STAGES+2 clks after the pin edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
      ss_fall_r <= 1'b0;
      ss_rise_r <= 1'b0;
      mosi_r    <= 1'b0;
    end else begin
      ss_q      <= ss_s;
      sclk_q    <= sclk_s;
      rise_r    <= sclk_s & ~sclk_q & ~ss_s;
      fall_r    <= ~sclk_s & sclk_q & ~ss_s;
      ss_fall_r <= ~ss_s & ss_q;
      ss_rise_r <= ss_s & ~ss_q;
      mosi_r    <= mosi_s;
    end
  end

  // Next-value helpers for the bit counter and word completion.
  always_comb begin
    shift_nxt = {shift_reg, mosi_r};
    cnt_inc   = bit_cnt + 1'b1;
    addr_inc  = (AUTO_INC != 0) ? addr_reg + 1'b1 : addr_reg;
    in_word   = (state == ST_DATA);
`ifdef SPI_READBACK_EN
    in_word   = in_word || (state == ST_READ);
`endif
    cmd_done  = rise_r && (state == ST_CMD) && (cnt_inc == CMD_BITS);
    word_done = rise_r && in_word && (cnt_inc == WORD_BITS);
    cnt_nxt   = bit_cnt;
    if (rise_r && ((state == ST_CMD) || in_word))
      cnt_nxt = (cmd_done || word_done) ? '0 : cnt_inc;
  end

  // Frame FSM: command decode, word assembly, write strobe and frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      addr_reg  <= '0;
      addr      <= '0;
      data      <= '0;
      write_en  <= 1'b0;
      data_rdy  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      ld_pend   <= 1'b0;
    end else begin
      write_en  <= 1'b0;
      frame_err <= 1'b0;
      ld_pend   <= 1'b0;
      if (state == ST_IDLE) begin
        if (ss_fall_r) begin
          state    <= ST_CMD;
          busy     <= 1'b1;
          data_rdy <= 1'b0;
          bit_cnt  <= '0;
        end
      end else begin
        bit_cnt <= cnt_nxt;
        if (rise_r && (state != ST_SKIP))
          shift_reg <= shift_nxt[SR_W-2:0];
        case (state)
          ST_CMD: begin
            if (cmd_done) begin
              if (!shift_nxt[7]) begin
                addr_reg <= shift_nxt[ADDR_W-1:0];
                state    <= ST_DATA;
              end else begin
`ifdef SPI_READBACK_EN
                addr_reg <= shift_nxt[ADDR_W-1:0];
                addr     <= shift_nxt[ADDR_W-1:0];
                ld_pend  <= 1'b1;
                state    <= ST_READ;
`else
                state    <= ST_SKIP;
`endif
              end
            end
          end
          ST_DATA: begin
            if (word_done) begin
              data     <= shift_nxt[DATA_W-1:0];
              addr     <= addr_reg;
              write_en <= 1'b1;
              data_rdy <= 1'b1;
              addr_reg <= addr_inc;
            end
          end
`ifdef SPI_READBACK_EN
          ST_READ: begin
            if (word_done) begin
              addr_reg <= addr_inc;
              addr     <= addr_inc;
              ld_pend  <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
        // Frame end overrides any state change above; a word finishing on
        // the same clk has already cleared cnt_nxt, so it raises no error.
        if (ss_rise_r) begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          bit_cnt   <= '0;
          frame_err <= (cnt_nxt != '0);
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_reg;
  logic              armed;

  // Read shifter: load one clk after addr settles; shift on sclk falls that
  // follow a rise, so the fall right after a word boundary keeps the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg <= '0;
      armed  <= 1'b0;
    end else if (ld_pend) begin
      tx_reg <= rd_data;
      armed  <= 1'b0;
    end else if (rise_r) begin
      armed  <= 1'b1;
    end else if (fall_r && armed && (state == ST_READ)) begin
      tx_reg <= tx_reg << 1;
      armed  <= 1'b0;
    end
  end

  assign miso = (state == ST_READ) ? tx_reg[DATA_W-1] : 1'b0;
`else
  assign miso = 1'b0;
`endif

endmodule
